seg_disp_to_bcd: RTL and testbench



---
 rtl/seg_disp_pkg.sv | 24 ++
 rtl/seg7_to_bcd.sv | 31 +++
 rtl/seg_disp_to_bcd.sv | 136 +++++++++++++
 tb/tb_seg_disp_to_bcd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and state type for the 7-segment readback block
package seg_disp_pkg;

   // Segment patterns in {a,b,c,d,e,f,g} order, a in the MSB.
   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      HELD  = 2'd2
   } disp_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational {a..g} segment pattern to BCD digit with error flag
module seg7_to_bcd
   import seg_disp_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_INVALID;
      err = 1'b1;
      case (seg)
         SEG_0: begin bcd = 4'd0; err = 1'b0; end
         SEG_1: begin bcd = 4'd1; err = 1'b0; end
         SEG_2: begin bcd = 4'd2; err = 1'b0; end
         SEG_3: begin bcd = 4'd3; err = 1'b0; end
         SEG_4: begin bcd = 4'd4; err = 1'b0; end
         SEG_5: begin bcd = 4'd5; err = 1'b0; end
         SEG_6: begin bcd = 4'd6; err = 1'b0; end
         SEG_7: begin bcd = 4'd7; err = 1'b0; end
         SEG_8: begin bcd = 4'd8; err = 1'b0; end
         SEG_9: begin bcd = 4'd9; err = 1'b0; end
         default: begin
            bcd = BCD_INVALID;
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_disp_to_bcd.sv
// rtl/seg_disp_to_bcd.sv - multiplexed 7-segment bus readback into a double-buffered BCD frame
module seg_disp_to_bcd
   import seg_disp_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   err_digit,
   output logic                    frame_err,
   output logic                    valid
);

   localparam int                    CW      = $clog2(STABLE_CYCLES + 1);
   localparam int                    IW      = NUM_DIGITS + 8;
   localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]         CNT_ONE = CW'(1);
   localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);
   localparam logic [NUM_DIGITS-1:0] DIG_ALL = '1;

   logic [IW-1:0]           cur_in;
   logic [IW-1:0]           prev_in;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nxt;
   disp_state_t             state;
   disp_state_t             state_nxt;
   logic                    changed;
   logic                    onehot;
   logic                    multihot;
   logic                    capture;
   logic                    frame_done;
   logic [3:0]              dec_bcd;
   logic                    dec_err;
   logic [NUM_DIGITS-1:0]   captured_mask;
   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [NUM_DIGITS-1:0]   shadow_err;
   logic                    shadow_frame_err;

   seg7_to_bcd u_dec (
      .seg (seg_in[7:1]),
      .bcd (dec_bcd),
      .err (dec_err)
   );

   assign cur_in     = {dig_en, seg_in};
   assign changed    = (cur_in != prev_in);
   assign onehot     = (dig_en != '0) && ((dig_en & (dig_en - DIG_ONE)) == '0);
   assign multihot   = (dig_en != '0) && !onehot;
   assign frame_done = (captured_mask == DIG_ALL);

   always_comb begin
      cnt_nxt = cnt;
      if (changed) begin
         cnt_nxt = CNT_ONE;
      end else if (cnt != CNT_MAX) begin
         cnt_nxt = cnt + CNT_ONE;
      end
   end

   // With a one-cycle dwell the change edge itself is the capture edge.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      if (changed) begin
         if (!onehot) begin
            state_nxt = IDLE;
         end else if (cnt_nxt == CNT_MAX) begin
            state_nxt = HELD;
            capture   = 1'b1;
         end else begin
            state_nxt = DWELL;
         end
      end else if ((state == DWELL) && (cnt_nxt == CNT_MAX)) begin
         state_nxt = HELD;
         capture   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         prev_in <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         prev_in <= cur_in;
         cnt     <= cnt_nxt;
      end
   end

   // A capture on the frame-completion edge belongs to the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         captured_mask    <= '0;
         shadow_bcd       <= '0;
         shadow_dp        <= '0;
         shadow_err       <= '0;
         shadow_frame_err <= 1'b0;
      end else begin
         captured_mask    <= (frame_done ? '0 : captured_mask) | (capture ? dig_en : '0);
         shadow_frame_err <= (frame_done ? 1'b0 : shadow_frame_err) | multihot;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && dig_en[i]) begin
               shadow_bcd[4*i +: 4] <= dec_bcd;
               shadow_dp[i]         <= seg_in[0];
               shadow_err[i]        <= dec_err;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_out   <= '0;
         dp_out    <= '0;
         err_digit <= '0;
         frame_err <= 1'b0;
         valid     <= 1'b0;
      end else begin
         valid <= frame_done;
         if (frame_done) begin
            bcd_out   <= shadow_bcd;
            dp_out    <= shadow_dp;
            err_digit <= shadow_err;
            frame_err <= shadow_frame_err;
         end
      end
   end

endmodule

// File: tb/tb_seg_disp_to_bcd.sv
// tb/tb_seg_disp_to_bcd.sv - scoreboard bench for seg_disp_to_bcd at dwell 4 and dwell 1
module tb_seg_disp_to_bcd;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  dp;
      logic [3:0]  err;
      logic        ferr;
      int          at_edge;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  seg_in;
   logic [3:0]  dig_en;
   logic [15:0] bcd_a, bcd_b;
   logic [3:0]  dp_a, dp_b, err_a, err_b;
   logic        ferr_a, ferr_b, valid_a, valid_b;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int edge_n   = 0;

   logic [6:0] pat [11] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                            7'b0000000};

   int          m_s [2] = '{4, 1};
   logic [11:0] m_last [2];
   int          m_run [2];
   logic [3:0]  m_mask [2];
   logic [15:0] m_bcd [2];
   logic [3:0]  m_dp [2];
   logic [3:0]  m_err [2];
   logic        m_ferr [2];
   logic        m_pend [2];
   exp_t        q0 [$];
   exp_t        q1 [$];

   int          vcount [2];
   logic [15:0] last_bcd [2];
   logic [3:0]  last_dp [2];
   logic [3:0]  last_err [2];
   logic        last_ferr [2];

   seg_disp_to_bcd #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut_a (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
      .bcd_out(bcd_a), .dp_out(dp_a), .err_digit(err_a), .frame_err(ferr_a), .valid(valid_a)
   );

   seg_disp_to_bcd #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
      .bcd_out(bcd_b), .dp_out(dp_b), .err_digit(err_b), .frame_err(ferr_b), .valid(valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n = edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int d = 0; d < 10; d++) if (s == pat[d]) return {1'b0, 4'(d)};
      return {1'b1, 4'hF};
   endfunction

   function automatic logic [7:0] sg(input int d, input bit dp);
      return {pat[d], dp};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_last[k] = '0; m_run[k] = 0; m_mask[k] = '0; m_bcd[k] = '0;
         m_dp[k] = '0; m_err[k] = '0; m_ferr[k] = 1'b0; m_pend[k] = 1'b0;
      end
   endtask

   // Behaviour at one sampling edge: a digit is read once its pattern has been
   // on the bus for exactly S consecutive samples; a full set of digits is
   // published one edge later.
   task automatic model_step(input int k, input logic [3:0] de, input logic [7:0] s);
      exp_t x;
      logic [4:0] dec;
      if (m_pend[k]) begin
         x.bcd = m_bcd[k]; x.dp = m_dp[k]; x.err = m_err[k]; x.ferr = m_ferr[k];
         x.at_edge = edge_n + 1;
         if (k == 0) q0.push_back(x); else q1.push_back(x);
         m_mask[k] = '0; m_ferr[k] = 1'b0; m_pend[k] = 1'b0;
      end
      if ({de, s} == m_last[k]) m_run[k]++; else m_run[k] = 1;
      m_last[k] = {de, s};
      if ($countones(de) > 1) m_ferr[k] = 1'b1;
      if ($countones(de) == 1 && m_run[k] == m_s[k]) begin
         dec = ref_decode(s[7:1]);
         for (int i = 0; i < 4; i++) begin
            if (de[i]) begin
               m_bcd[k][4*i +: 4] = dec[3:0];
               m_dp[k][i]  = s[0];
               m_err[k][i] = dec[4];
               m_mask[k][i] = 1'b1;
            end
         end
      end
      if (m_mask[k] == 4'hF) m_pend[k] = 1'b1;
   endtask

   task automatic drive(input logic [3:0] de, input logic [7:0] s, input int n);
      repeat (n) begin
         @(negedge clk);
         dig_en = de;
         seg_in = s;
         model_step(0, de, s);
         model_step(1, de, s);
      end
   endtask

   task automatic scan4(input int d0, input int d1, input int d2, input int d3, input int n);
      drive(4'b0001, sg(d0, 0), n);
      drive(4'b0010, sg(d1, 0), n);
      drive(4'b0100, sg(d2, 0), n);
      drive(4'b1000, sg(d3, 0), n);
      drive(4'b0000, 8'h00, 3);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; dig_en = '0; seg_in = '0;
      model_reset();
      repeat (n) @(negedge clk);
      check("rst_out_a", 32'({bcd_a, dp_a, err_a, ferr_a, valid_a}), 32'h0);
      check("rst_out_b", 32'({bcd_b, dp_b, err_b, ferr_b, valid_b}), 32'h0);
      rst = 1'b0;
      model_step(0, dig_en, seg_in);
      model_step(1, dig_en, seg_in);
   endtask

   task automatic mon(input int k, input logic [15:0] b, input logic [3:0] d,
                      input logic [3:0] e, input logic f);
      exp_t x;
      vcount[k]++;
      last_bcd[k] = b; last_dp[k] = d; last_err[k] = e; last_ferr[k] = f;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
         chk_cnt++;
         $display("FAIL unexpected_valid%0d at edge %0d: got valid=1 expected no frame", k, edge_n);
         return;
      end
      if (k == 0) x = q0.pop_front(); else x = q1.pop_front();
      check($sformatf("frame%0d", k), 32'({b, d, e, f}), 32'({x.bcd, x.dp, x.err, x.ferr}));
      check($sformatf("valid_edge%0d", k), 32'(edge_n), 32'(x.at_edge));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_a) mon(0, bcd_a, dp_a, err_a, ferr_a);
         if (valid_b) mon(1, bcd_b, dp_b, err_b, ferr_b);
      end
   end

   initial begin
      logic [3:0] de;
      logic [7:0] s;
      int r;
      rst = 1'b1; dig_en = '0; seg_in = '0;
      vcount[0] = 0; vcount[1] = 0;
      model_reset();
      do_reset(3);

      scan4(1, 2, 3, 4, 4);
      check("scan_bcd", 32'(last_bcd[0]), 32'h4321);
      check("scan_err", 32'(last_err[0]), 32'h0);

      scan4(1, 2, 10, 4, 4);
      check("blank_bcd", 32'(last_bcd[0]), 32'h4F21);
      check("blank_err", 32'(last_err[0]), 32'h4);

      drive(4'b0001, sg(5, 0), 4);
      drive(4'b0010, sg(7, 0), 4);
      drive(4'b0010, sg(8, 0), 3);
      drive(4'b0100, sg(3, 0), 4);
      drive(4'b1000, sg(9, 0), 4);
      drive(4'b0000, 8'h00, 3);
      check("glitch_bcd", 32'(last_bcd[0]), 32'h9375);

      drive(4'b0001, sg(1, 0), 4);
      drive(4'b0011, sg(2, 0), 5);
      drive(4'b0010, sg(2, 0), 4);
      drive(4'b0100, sg(3, 0), 4);
      drive(4'b1000, sg(4, 0), 4);
      drive(4'b0000, 8'h00, 3);
      check("multihot_ferr", 32'(last_ferr[0]), 32'h1);
      scan4(5, 6, 7, 8, 4);
      check("clean_ferr", 32'(last_ferr[0]), 32'h0);

      drive(4'b0001, sg(1, 0), 4);
      drive(4'b0010, sg(1, 0), 4);
      drive(4'b0100, sg(1, 0), 4);
      do_reset(2);
      vcount[0] = 0;
      scan4(9, 8, 7, 6, 4);
      drive(4'b0000, 8'h00, 6);
      check("post_rst_valids", 32'(vcount[0]), 32'h1);
      check("post_rst_bcd", 32'(last_bcd[0]), 32'h6789);

      drive(4'b0001, sg(5, 1), 1);
      drive(4'b0010, sg(2, 0), 1);
      drive(4'b0100, sg(3, 0), 1);
      drive(4'b1000, sg(4, 0), 1);
      drive(4'b0000, 8'h00, 3);
      check("s1_dp0", 32'(last_dp[1][0]), 32'h1);
      check("s1_nib0", 32'(last_bcd[1][3:0]), 32'h5);

      drive(4'b0001, sg(0, 0), 30);
      drive(4'b0010, sg(0, 0), 4);
      drive(4'b0100, sg(0, 0), 4);
      drive(4'b1000, sg(0, 0), 4);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      de = 4'(1 << $urandom_range(0, 3));
         else if (r < 8) de = 4'b0000;
         else            de = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) s = 8'($urandom_range(0, 255));
         else s = sg($urandom_range(0, 9), 1'($urandom_range(0, 1)));
         drive(de, s, $urandom_range(1, 7));
      end
      drive(4'b0000, 8'h00, 10);

      check("q0_drained", 32'(q0.size()), 32'h0);
      check("q1_drained", 32'(q1.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
